// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU.
// Single-cycle logic/arithmetic/shift ops, iterative shift-add MULTU.
// Optional restoring DIVU, enabled by defining ALU_MC_DIVU_EN.
// Results are registered; done pulses for one cycle when they are valid.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;
`ifdef ALU_MC_DIVU_EN
    localparam logic [5:0] F_DIVU  = 6'd27;
`endif

    // Iteration counter must be able to hold WIDTH itself.
    localparam int            CW       = SHW + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    // Multiplicand for MULTU, divisor for DIVU.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // MULTU: {partial product, remaining multiplier bits} -- the multiplier
    // occupies the low half and is shifted out as product bits shift in.
    // DIVU: {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               is_mul;
    logic               is_div;
    logic [WIDTH-1:0]   sub_res;
    logic               slt_ovf;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   one_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
`ifdef ALU_MC_DIVU_EN
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign is_mul = (Signal == F_MULTU);
`ifdef ALU_MC_DIVU_EN
    assign is_div = (Signal == F_DIVU);
`else
    assign is_div = 1'b0;
`endif

    // Single-cycle result; SLT uses sign of A-B corrected by signed overflow.
    always_comb begin
        sub_res = dataA - dataB;
        slt_ovf = (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & (sub_res[WIDTH-1] ^ dataA[WIDTH-1]);
        shamt   = dataB[SHW-1:0];
        one_res = '0;
        case (Signal)
            F_AND:   one_res = dataA & dataB;
            F_OR:    one_res = dataA | dataB;
            F_ADD:   one_res = dataA + dataB;
            F_SUB:   one_res = sub_res;
            F_SLT:   one_res = {{(WIDTH-1){1'b0}}, sub_res[WIDTH-1] ^ slt_ovf};
            F_SLL:   one_res = dataA << shamt;
            F_SRL:   one_res = dataA >> shamt;
            default: one_res = '0;
        endcase
    end

    // One shift-add step: conditional add into upper half with carry, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef ALU_MC_DIVU_EN
    // One restoring-divide step; a zero divisor naturally yields all-ones
    // quotient with the dividend left as remainder.
    always_comb begin
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = rem_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul)      state_d = S_MUL;
                    else if (is_div) state_d = S_DIV;
                    else             state_d = S_DONE;
                end
            end
            S_MUL:   if (cnt_q == CNT_ONE) state_d = S_DONE;
`ifdef ALU_MC_DIVU_EN
            S_DIV:   if (cnt_q == CNT_ONE) state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy during iterations, done for the single DONE cycle.
    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_DIV);
        done = (state_q == S_DONE);
    end

    // Datapath next-state: operand capture, iteration, result write-back.
    always_comb begin
        dout_d = dout_q;
        hi_d   = hi_q;
        zero_d = zero_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        opnd_d = dataA;
                        acc_d  = {{WIDTH{1'b0}}, dataB};
                        cnt_d  = CNT_INIT;
                    end else if (is_div) begin
                        opnd_d = dataB;
                        acc_d  = {{WIDTH{1'b0}}, dataA};
                        cnt_d  = CNT_INIT;
                    end else begin
                        dout_d = one_res;
                        hi_d   = '0;
                        zero_d = (one_res == '0);
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    dout_d = mul_next[WIDTH-1:0];
                    hi_d   = mul_next[2*WIDTH-1:WIDTH];
                    zero_d = (mul_next[WIDTH-1:0] == '0);
                end
            end
`ifdef ALU_MC_DIVU_EN
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    dout_d = div_next[WIDTH-1:0];
                    hi_d   = div_next[2*WIDTH-1:WIDTH];
                    zero_d = (div_next[WIDTH-1:0] == '0);
                end
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            hi_q   <= '0;
            zero_q <= 1'b1;
            opnd_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            dout_q <= dout_d;
            hi_q   <= hi_d;
            zero_q <= zero_d;
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dataOut = dout_q;
    assign hi      = hi_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH=32). Optional DIVU checks follow ALU_MC_DIVU_EN.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [5:0]   Signal;
    logic [W-1:0] dataOut;
    logic [W-1:0] hi;
    logic         zero;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    alu_mc #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .hi      (hi),
        .zero    (zero),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        Signal = op;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        Signal = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset dataOut got %h want 00000000", dataOut); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset hi got %h want 00000000", hi); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset zero got %b want 1", zero); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: dataOut=%h hi=%h zero=%b busy=%b done=%b", dataOut, hi, zero, busy, done);
    endtask

    task automatic test_add;
        issue(6'd32, 32'h7FFF_FFFF, 32'h0000_0001);
        $display("ADD 7fffffff+1: dataOut=%h zero=%b done=%b busy=%b", dataOut, zero, done, busy);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add done got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add busy got %b want 0", busy); end
        n_checks++; if (dataOut !== 32'h8000_0000) begin n_fail++; $display("FAIL add dataOut got %h want 80000000", dataOut); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add zero got %b want 0", zero); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add done_pulse got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add busy_after got %b want 0", busy); end
        n_checks++; if (dataOut !== 32'h8000_0000) begin n_fail++; $display("FAIL add hold got %h want 80000000", dataOut); end
    endtask

    task automatic test_multu;
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W-1:0] tlo[3];
        logic [W-1:0] thi[3];
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; tlo[0] = 32'h0000_0001; thi[0] = 32'hFFFF_FFFE;
        ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0005; tlo[1] = 32'h0000_0000; thi[1] = 32'h0000_0000;
        ta[2] = 32'd1234;      tb[2] = 32'd5678;      tlo[2] = 32'h006A_E9BC; thi[2] = 32'h0000_0000;
        for (int v = 0; v < 3; v++) begin
            int cyc;
            int busy_cnt;
            issue(6'd25, ta[v], tb[v]);
            cyc = 0;
            busy_cnt = 0;
            while (done !== 1'b1 && cyc < 100) begin
                if (busy === 1'b1) busy_cnt++;
                // A stray request mid-operation must be ignored.
                if (cyc == 5) begin
                    start = 1'b1; Signal = 6'd32; dataA = 32'd2; dataB = 32'd3;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            start = 1'b0;
            $display("MULTU %h*%h: cycles=%0d busy_cycles=%0d hi=%h dataOut=%h zero=%b", ta[v], tb[v], cyc, busy_cnt, hi, dataOut, zero);
            n_checks++; if (cyc != 32) begin n_fail++; $display("FAIL mul%0d latency got %0d want 32", v, cyc); end
            n_checks++; if (busy_cnt != 32) begin n_fail++; $display("FAIL mul%0d busy_cycles got %0d want 32", v, busy_cnt); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul%0d busy_at_done got %b want 0", v, busy); end
            n_checks++; if (dataOut !== tlo[v]) begin n_fail++; $display("FAIL mul%0d dataOut got %h want %h", v, dataOut, tlo[v]); end
            n_checks++; if (hi !== thi[v]) begin n_fail++; $display("FAIL mul%0d hi got %h want %h", v, hi, thi[v]); end
            n_checks++; if (zero !== (tlo[v] == '0)) begin n_fail++; $display("FAIL mul%0d zero got %b want %b", v, zero, (tlo[v] == '0)); end
            @(posedge clk);
            #1;
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul%0d done_pulse got %b want 0", v, done); end
        end
    endtask

    task automatic test_single_ops;
        logic [5:0]   top [8];
        logic [W-1:0] ta  [8];
        logic [W-1:0] tb  [8];
        logic [W-1:0] tex [8];
        top[0] = 6'd36; ta[0] = 32'hF0F0_F0F0; tb[0] = 32'hFF00_FF00; tex[0] = 32'hF000_F000;
        top[1] = 6'd37; ta[1] = 32'hF0F0_F0F0; tb[1] = 32'hFF00_FF00; tex[1] = 32'hFFF0_FFF0;
        top[2] = 6'd34; ta[2] = 32'd5;         tb[2] = 32'd5;         tex[2] = 32'h0000_0000;
        top[3] = 6'd42; ta[3] = 32'hFFFF_FFFF; tb[3] = 32'd1;         tex[3] = 32'h0000_0001;
        top[4] = 6'd42; ta[4] = 32'h7FFF_FFFF; tb[4] = 32'h8000_0000; tex[4] = 32'h0000_0000;
        top[5] = 6'd0;  ta[5] = 32'h0000_0001; tb[5] = 32'h0000_0023; tex[5] = 32'h0000_0008;
        top[6] = 6'd2;  ta[6] = 32'h8000_0000; tb[6] = 32'd31;        tex[6] = 32'h0000_0001;
        top[7] = 6'd63; ta[7] = 32'd5;         tb[7] = 32'd3;         tex[7] = 32'h0000_0000;
        for (int v = 0; v < 8; v++) begin
            issue(top[v], ta[v], tb[v]);
            $display("op %0d a=%h b=%h: dataOut=%h hi=%h zero=%b done=%b", top[v], ta[v], tb[v], dataOut, hi, zero, done);
            n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL op%0d done got %b want 1", v, done); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL op%0d busy got %b want 0", v, busy); end
            n_checks++; if (dataOut !== tex[v]) begin n_fail++; $display("FAIL op%0d dataOut got %h want %h", v, dataOut, tex[v]); end
            n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL op%0d hi got %h want 00000000", v, hi); end
            n_checks++; if (zero !== (tex[v] == '0)) begin n_fail++; $display("FAIL op%0d zero got %b want %b", v, zero, (tex[v] == '0)); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midop;
        int seen_done;
        issue(6'd25, 32'd1234, 32'd5678);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        $display("reset mid-MULTU: dataOut=%h hi=%h zero=%b busy=%b done=%b", dataOut, hi, zero, busy, done);
        n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL midrst dataOut got %h want 00000000", dataOut); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midrst hi got %h want 00000000", hi); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL midrst zero got %b want 1", zero); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy got %b want 0", busy); end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL midrst activity got %0d want 0", seen_done); end
        issue(6'd32, 32'd3, 32'd4);
        $display("ADD 3+4 after reset: dataOut=%h zero=%b done=%b", dataOut, zero, done);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL postrst done got %b want 1", done); end
        n_checks++; if (dataOut !== 32'd7) begin n_fail++; $display("FAIL postrst dataOut got %h want 00000007", dataOut); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL postrst zero got %b want 0", zero); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_divu;
`ifdef ALU_MC_DIVU_EN
        logic [W-1:0] ta [2];
        logic [W-1:0] tb [2];
        logic [W-1:0] tq [2];
        logic [W-1:0] tr [2];
        ta[0] = 32'd100; tb[0] = 32'd7; tq[0] = 32'd14;        tr[0] = 32'd2;
        ta[1] = 32'd9;   tb[1] = 32'd0; tq[1] = 32'hFFFF_FFFF; tr[1] = 32'd9;
        for (int v = 0; v < 2; v++) begin
            int cyc;
            issue(6'd27, ta[v], tb[v]);
            cyc = 0;
            while (done !== 1'b1 && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            $display("DIVU %0d/%0d: cycles=%0d dataOut=%h hi=%h", ta[v], tb[v], cyc, dataOut, hi);
            n_checks++; if (cyc != 32) begin n_fail++; $display("FAIL div%0d latency got %0d want 32", v, cyc); end
            n_checks++; if (dataOut !== tq[v]) begin n_fail++; $display("FAIL div%0d dataOut got %h want %h", v, dataOut, tq[v]); end
            n_checks++; if (hi !== tr[v]) begin n_fail++; $display("FAIL div%0d hi got %h want %h", v, hi, tr[v]); end
            @(posedge clk);
            #1;
        end
`else
        issue(6'd27, 32'd100, 32'd7);
        $display("code 27 (no DIVU): dataOut=%h hi=%h zero=%b done=%b busy=%b", dataOut, hi, zero, done, busy);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL divoff done got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL divoff busy got %b want 0", busy); end
        n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL divoff dataOut got %h want 00000000", dataOut); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL divoff hi got %h want 00000000", hi); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL divoff zero got %b want 1", zero); end
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add();
        test_multu();
        test_single_ops();
        test_reset_midop();
        test_divu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Executes the same funct-coded logic and arithmetic ops plus logical shifts and an iterative unsigned multiply (shift-add). Optional unsigned divide.
- Sits in the EX stage. Hazard logic stalls the pipe while busy is high. Results are registered and qualified by a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), shift-amount width taken from dataB[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; samples dataA, dataB and Signal when high and the unit is not busy.
- dataA  input  WIDTH  operand A.
- dataB  input  WIDTH  operand B.
- Signal  input  6  funct code.
- dataOut  output  WIDTH  result (LO for MULTU, quotient for DIVU).
- hi  output  WIDTH  MULTU upper half or DIVU remainder; 0 for all other ops.
- zero  output  1  high when dataOut == 0.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse: dataOut, hi and zero are valid.

Behaviour:
- Reset (async, rst_n low): state=IDLE, dataOut=0, hi=0, zero=1, busy=0, done=0. All internal accumulators and counters are cleared.
- Funct codes:
  - AND=36 (A&B), OR=37 (A|B), ADD=32 (A+B mod 2^WIDTH), SUB=34 (A-B mod 2^WIDTH).
  - SLT=42: 1 if signed A<B, else 0. Computed from the sign of A-B xor overflow, so it is correct across the sign boundary.
  - SLL=0: A<<B[SHW-1:0]. SRL=2: A>>B[SHW-1:0], logical, zero fill.
  - MULTU=25.
  - Any other code: dataOut=0, hi=0, zero=1. Completes as a single-cycle op.
- FSM states: IDLE, MUL, (DIV when DIVU_EN is defined), DONE.
- IDLE, start=1, single-cycle op: result registered at that edge; next state DONE. done=1 in the following cycle; busy stays 0.
- IDLE, start=1, MULTU: latch multiplicand, multiplier and count=WIDTH; clear the 2*WIDTH-bit product; set busy=1; next state MUL.
- MUL: each cycle, if multiplier LSB=1, add the multiplicand into the product upper half with carry. Then shift {carry,product} right by 1 and decrement count. When count reaches 1 the final iteration writes {hi,dataOut}; next state DONE.
- MULTU latency: start edge E0, done high in the cycle after edge E0+WIDTH. busy is high for exactly WIDTH cycles.
- DONE: done=1 for one cycle, busy=0, then IDLE. A start present during DONE is not accepted; issuers must wait for IDLE.
- start while busy or DONE is ignored; inputs are not re-sampled.
- Outputs hold their last values until the next completion. zero updates only with dataOut.
- MULTU with an operand of 0 still takes the full WIDTH cycles; no early termination.
- Reset mid-operation aborts immediately to reset values. No partial result and no done pulse.

Optional Feature:
- Macro ALU_MC_DIVU_EN.
- Defined: DIVU=27 is accepted. It is a restoring divider, WIDTH iterations, with the same latency and handshake as MULTU. dataOut=quotient, hi=remainder.
- Divide by zero: quotient all-ones, remainder = dataA. Timing is unchanged.
- Not defined: DIVU=27 is treated as an unknown code: dataOut=0, hi=0, zero=1, single-cycle.

Test Plan (WIDTH=32):
- Reset then ADD 0x7FFFFFFF+1: done one cycle after start; dataOut=0x80000000, zero=0, busy never high.
- SUB 5-5: dataOut=0, zero=1. SLT -1 vs 1: dataOut=1. SLT 0x7FFFFFFF vs 0x80000000: dataOut=0.
- SLL 0x1 by dataB=0x23 (uses 3): dataOut=0x8. SRL 0x80000000 by 31: dataOut=1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF: busy 32 cycles; done in the cycle after the 32nd iteration edge; hi=0xFFFFFFFE, dataOut=0x00000001. A second start pulsed mid-op is ignored.
- MULTU 1234*5678, rst_n low at iteration 10: outputs go to reset values at once and no done pulse. A new ADD issued after release completes normally.
- With ALU_MC_DIVU_EN: DIVU 100/7 gives dataOut=14, hi=2. DIVU 9/0 gives dataOut=0xFFFFFFFF, hi=9. Without the macro, code 27 gives dataOut=0, zero=1, single-cycle.
